// File: rtl/hex_flash_sched_if.sv
// Bundle of the request/flash signals between the requesters, the scheduler
// and the per-digit flash units.
interface hex_flash_sched_if;
    logic [3:0] req;
    logic       hold;
    logic [3:0] enable;
    logic [3:0] interx;
    logic [1:0] grant_id;
    logic       busy;

    // Requester side: raises requests and hold, watches the grant.
    modport master (
        output req,
        output hold,
        input  enable,
        input  interx,
        input  grant_id,
        input  busy
    );

    // Scheduler side.
    modport slave (
        input  req,
        input  hold,
        output enable,
        output interx,
        output grant_id,
        output busy
    );
endinterface

// File: rtl/hex_flash_sched.sv
// Round-robin scheduler handing the flash enable of a 4-digit HEX bank to one
// digit at a time: a dwell of DWELL cycles per grant, then GAP_LEN blank
// cycles. Every digit that is not granted gets its interrupt held high.
module hex_flash_sched #(
    parameter int              CNT_W   = 8,
    parameter logic [CNT_W-1:0] DWELL   = 8'd200,
    parameter logic [CNT_W-1:0] GAP_LEN = 8'd2
) (
    input  logic              clk,
    input  logic              reset,
    hex_flash_sched_if.slave  bus
);
    localparam logic [CNT_W-1:0] DWELL_LOAD = DWELL - CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = GAP_LEN - CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       ptr_reg, ptr_next;
    logic [CNT_W-1:0] dwell_reg, dwell_next;
    logic [CNT_W-1:0] gap_reg, gap_next;
    logic [3:0]       enable_reg, enable_next;
    logic [3:0]       interx_reg;
    logic [1:0]       grant_id_reg, grant_id_next;
    logic             busy_reg;

    // Rotated search order: candidate gi is the digit examined gi-th,
    // starting from the round-robin pointer.
    logic [1:0] cand [4];
    logic [3:0] hit;
    logic [1:0] sel_idx;
    logic [3:0] sel_onehot;
    logic       launch;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_search
            assign cand[gi]       = ptr_reg + 2'(gi);
            assign hit[gi]        = bus.req[cand[gi]];
            assign sel_onehot[gi] = (sel_idx == 2'(gi));
        end
    endgenerate

    // Pick the first requesting candidate in rotated order (earliest wins).
    always_comb begin
        sel_idx = cand[0];
        for (int k = 3; k >= 0; k--) begin
            if (hit[k]) begin
                sel_idx = cand[k];
            end
        end
    end

    // Next-state and next-output logic for IDLE / GRANT / GAP.
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        dwell_next    = dwell_reg;
        gap_next      = gap_reg;
        enable_next   = enable_reg;
        grant_id_next = grant_id_reg;
        launch        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.req != 4'b0000) begin
                    launch = 1'b1;
                end
            end
            ST_GRANT: begin
                // Withdrawal ends the grant regardless of hold or counter;
                // hold at a zero counter stretches the grant.
                if (!bus.req[grant_id_reg] ||
                    (dwell_reg == '0 && !bus.hold)) begin
                    state_next  = ST_GAP;
                    ptr_next    = grant_id_reg + 2'd1;
                    gap_next    = GAP_LOAD;
                    enable_next = 4'b0000;
                end else if (!bus.hold) begin
                    dwell_next = dwell_reg - 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_reg == '0) begin
                    if (bus.req != 4'b0000) begin
                        launch = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    gap_next = gap_reg - 1'b1;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                enable_next = 4'b0000;
            end
        endcase

        if (launch) begin
            state_next    = ST_GRANT;
            grant_id_next = sel_idx;
            enable_next   = sel_onehot;
            dwell_next    = DWELL_LOAD;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= 2'd0;
            dwell_reg    <= '0;
            gap_reg      <= '0;
            enable_reg   <= 4'b0000;
            interx_reg   <= 4'b1111;
            grant_id_reg <= 2'd0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            dwell_reg    <= dwell_next;
            gap_reg      <= gap_next;
            enable_reg   <= enable_next;
            interx_reg   <= ~enable_next;
            grant_id_reg <= grant_id_next;
            busy_reg     <= (state_next == ST_GRANT);
        end
    end

    assign bus.enable   = enable_reg;
    assign bus.interx   = interx_reg;
    assign bus.grant_id = grant_id_reg;
    assign bus.busy     = busy_reg;
endmodule

// File: tb/tb_hex_flash_sched.sv
// Bench for hex_flash_sched with DWELL=4, GAP_LEN=2: directed scenarios plus
// a randomized run, all compared against a grant-level behavioural model.
module tb_hex_flash_sched;
    localparam int DW = 4;
    localparam int GL = 2;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    hex_flash_sched_if bus();

    hex_flash_sched #(.CNT_W(8), .DWELL(8'd4), .GAP_LEN(8'd2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: who owns the flash, how many un-held grant cycles remain,
    // how many blank cycles remain, where the rotation resumes.
    int         m_owner;
    int         m_rem;
    int         m_gap;
    int         m_ptr;
    logic [1:0] m_gid;

    function automatic logic [3:0] m_en();
        if (m_owner >= 0) return 4'(1 << m_owner);
        return 4'b0000;
    endfunction

    task automatic m_pick(input logic [3:0] r);
        m_owner = -1;
        for (int k = 0; k < 4; k++) begin
            int d;
            d = (m_ptr + k) % 4;
            if (m_owner < 0 && r[d]) m_owner = d;
        end
        if (m_owner >= 0) begin
            m_gid = 2'(m_owner);
            m_rem = DW;
            $display("t=%0t grant digit %0d req=%b", $time, m_owner, r);
        end
    endtask

    task automatic m_edge(input logic rst, input logic [3:0] r, input logic h);
        if (rst) begin
            m_owner = -1; m_rem = 0; m_gap = 0; m_ptr = 0; m_gid = 2'd0;
        end else if (m_owner >= 0) begin
            logic done;
            done = 1'b0;
            if (!r[m_owner]) done = 1'b1;
            else if (!h) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) done = 1'b1;
            end
            if (done) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_gap   = GL;
            end
        end else if (m_gap > 0) begin
            m_gap = m_gap - 1;
            if (m_gap == 0) m_pick(r);
        end else begin
            m_pick(r);
        end
    endtask

    // Advance one clock; inputs are stable from the previous falling edge.
    task automatic step();
        m_edge(reset, bus.req, bus.hold);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.req = 4'b0000; bus.hold = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.enable !== 4'b0000 || bus.interx !== 4'b1111 ||
            bus.grant_id !== 2'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: en=%b ix=%b gid=%0d busy=%b want 0000/1111/0/0",
                     bus.enable, bus.interx, bus.grant_id, bus.busy);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.enable !== 4'b0000 || bus.interx !== 4'b1111 ||
                bus.grant_id !== 2'd0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: en=%b ix=%b gid=%0d busy=%b want 0000/1111/0/0",
                         i, bus.enable, bus.interx, bus.grant_id, bus.busy);
            end
        end
    endtask

    task automatic test_single();
        bus.req = 4'b0100;
        for (int i = 0; i < 18; i++) begin
            logic [3:0] want;
            step();
            want = (i % 6 < 4) ? 4'b0100 : 4'b0000;
            checks++;
            if (bus.enable !== want || bus.interx !== ~want ||
                bus.grant_id !== 2'd2 || bus.busy !== (want != 4'b0000)) begin
                errors++;
                $display("FAIL single cyc%0d: en=%b ix=%b gid=%0d busy=%b want en=%b gid=2",
                         i, bus.enable, bus.interx, bus.grant_id, bus.busy, want);
            end
            checks++;
            if (bus.enable !== m_en() || bus.grant_id !== m_gid) begin
                errors++;
                $display("FAIL single_model cyc%0d: en=%b gid=%0d want en=%b gid=%0d",
                         i, bus.enable, bus.grant_id, m_en(), m_gid);
            end
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_rotation();
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 30; i++) begin
            logic [3:0] want;
            step();
            want = (i % 6 < 4) ? 4'(1 << ((i / 6) % 4)) : 4'b0000;
            checks++;
            if (bus.enable !== want || bus.interx !== ~want ||
                bus.busy !== (want != 4'b0000) || $countones(bus.enable) > 1) begin
                errors++;
                $display("FAIL rotation cyc%0d: en=%b ix=%b busy=%b want en=%b",
                         i, bus.enable, bus.interx, bus.busy, want);
            end
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_hold();
        do_reset();
        bus.req = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            logic [3:0] want;
            step();
            want = (k <= 7 || k >= 10) ? 4'b0001 : 4'b0000;
            checks++;
            if (bus.enable !== want || bus.busy !== (want != 4'b0000) ||
                bus.enable !== m_en()) begin
                errors++;
                $display("FAIL hold cyc%0d: en=%b busy=%b want en=%b model=%b",
                         k, bus.enable, bus.busy, want, m_en());
            end
            bus.hold = (k >= 2 && k <= 4);
        end
        bus.hold = 1'b0;
        bus.req  = 4'b0000;
    endtask

    task automatic test_withdraw();
        do_reset();
        bus.req = 4'b0010;
        step();
        step();
        checks++;
        if (bus.enable !== 4'b0010 || bus.grant_id !== 2'd1) begin
            errors++;
            $display("FAIL withdraw_grant: en=%b gid=%0d want 0010/1", bus.enable, bus.grant_id);
        end
        bus.req = 4'b0000; bus.hold = 1'b1;
        step();
        checks++;
        if (bus.enable !== 4'b0000 || bus.busy !== 1'b0 || bus.grant_id !== 2'd1 ||
            bus.interx !== 4'b1111) begin
            errors++;
            $display("FAIL withdraw_drop: en=%b busy=%b gid=%0d want 0000/0/1",
                     bus.enable, bus.busy, bus.grant_id);
        end
        bus.hold = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.enable !== 4'b0000 || bus.enable !== m_en()) begin
                errors++;
                $display("FAIL withdraw_gap cyc%0d: en=%b want 0000", i, bus.enable);
            end
        end
        bus.req = 4'b0011;
        step();
        checks++;
        if (bus.grant_id !== 2'd0 || bus.enable !== 4'b0001 || bus.grant_id !== m_gid) begin
            errors++;
            $display("FAIL withdraw_wrap: gid=%0d en=%b want gid=0 en=0001",
                     bus.grant_id, bus.enable);
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req = 4'b1000;
        step(); step(); step();
        checks++;
        if (bus.enable !== 4'b1000 || bus.grant_id !== 2'd3) begin
            errors++;
            $display("FAIL midreset_pre: en=%b gid=%0d want 1000/3", bus.enable, bus.grant_id);
        end
        reset = 1'b1; bus.req = 4'b1111;
        step();
        reset = 1'b0;
        checks++;
        if (bus.enable !== 4'b0000 || bus.interx !== 4'b1111 ||
            bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL midreset_clear: en=%b ix=%b busy=%b gid=%0d want 0000/1111/0/0",
                     bus.enable, bus.interx, bus.busy, bus.grant_id);
        end
        step();
        checks++;
        if (bus.enable !== 4'b0001 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL midreset_first: en=%b gid=%0d want 0001/0", bus.enable, bus.grant_id);
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.hold = ($urandom_range(0, 5) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            step();
            checks++;
            if (bus.enable !== m_en() || bus.interx !== ~m_en() ||
                bus.grant_id !== m_gid || bus.busy !== (m_owner >= 0)) begin
                errors++;
                $display("FAIL random cyc%0d: en=%b ix=%b gid=%0d busy=%b want en=%b gid=%0d",
                         i, bus.enable, bus.interx, bus.grant_id, bus.busy, m_en(), m_gid);
            end
            checks++;
            if ($countones(bus.enable) > 1 || bus.interx !== ~bus.enable ||
                bus.busy !== (bus.enable != 4'b0000)) begin
                errors++;
                $display("FAIL invariant cyc%0d: en=%b ix=%b busy=%b",
                         i, bus.enable, bus.interx, bus.busy);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; bus.req = 4'b0000; bus.hold = 1'b0;
        m_owner = -1; m_rem = 0; m_gap = 0; m_ptr = 0; m_gid = 2'd0;
        @(negedge clk);
        test_reset();
        test_single();
        test_rotation();
        test_hold();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
